// File: rtl/full_adder_pkg.sv
// Shared constants and result payload for the registered ripple-carry adder.
package full_adder_pkg;

   localparam int unsigned FA_DEFAULT_WIDTH = 1;

   // Full result of one addition: carry out above the sum bits.
   typedef struct packed {
      logic                        cout;
      logic [FA_DEFAULT_WIDTH-1:0] sum;
   } fa_result_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder cell, purely combinational.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;

   // Propagate term is shared by the sum and the carry.
   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder_bit

// File: rtl/full_adder_instantiation.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin.
// REG_INPUTS=1 adds an input register stage (latency 2), otherwise latency 1.
// Optional signed-overflow output enabled by macro FULL_ADDER_OVF_EN.
module full_adder_instantiation
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH      = FA_DEFAULT_WIDTH,
   parameter int unsigned REG_INPUTS = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic             cin_s;
   logic             vld_s;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c;

   if (REG_INPUTS != 0) begin : g_in_reg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             cin_q;
      logic             vld_q;

      // Input stage: operands only load when qualified, so idle garbage never enters.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            vld_q <= 1'b0;
         end else begin
            vld_q <= in_valid;
            if (in_valid) begin
               a_q   <= a;
               b_q   <= b;
               cin_q <= cin;
            end
         end
      end

      assign a_s   = a_q;
      assign b_s   = b_q;
      assign cin_s = cin_q;
      assign vld_s = vld_q;
   end else begin : g_in_comb
      assign a_s   = a;
      assign b_s   = b;
      assign cin_s = cin;
      assign vld_s = in_valid;
   end

   assign carry[0] = cin_s;

   // Ripple chain: one cell per bit, carry flows LSB to MSB.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      full_adder_bit u_bit (
         .a    (a_s[i]),
         .b    (b_s[i]),
         .cin  (carry[i]),
         .sum  (sum_c[i]),
         .cout (carry[i+1])
      );
   end

`ifdef FULL_ADDER_OVF_EN
   logic ovf_c;

   // Signed overflow: operands share a sign that the result does not.
   assign ovf_c = (a_s[MSB] == b_s[MSB]) && (sum_c[MSB] != a_s[MSB]);
`endif

   // Output stage: results hold while idle, valid tracks the qualifier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         out_valid <= vld_s;
         if (vld_s) begin
            sum  <= sum_c;
            cout <= carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
            ovf  <= ovf_c;
`endif
         end
      end
   end

endmodule : full_adder_instantiation

// File: tb/tb_full_adder_instantiation.sv
// Bench for full_adder_instantiation: WIDTH=1, WIDTH=8 and WIDTH=4/REG_INPUTS=1
// instances run side by side against an arithmetic reference model.
module tb_full_adder_instantiation;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_errors;

   // Per-instance stimulus and model state, index 0:w1, 1:w8, 2:w4 registered inputs.
   int in_a   [3];
   int in_b   [3];
   int in_cin [3];
   int in_vld [3];
   int ex_sum [3];
   int ex_cout[3];
   int ex_ovf [3];
   int ex_vld [3];
   int got_sum[3];
   int got_cout[3];
   int got_ovf[3];
   int got_vld[3];

   int p_a, p_b, p_cin, p_vld;

   logic       sum1, cout1, ovld1;
   logic [7:0] sum8;
   logic       cout8, ovld8;
   logic [3:0] sum4;
   logic       cout4, ovld4;
   logic       ovf1, ovf8, ovf4;

   localparam int WID[3] = '{1, 8, 4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   full_adder_instantiation #(.WIDTH(1), .REG_INPUTS(0)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_vld[0][0]),
      .a(in_a[0][0]), .b(in_b[0][0]), .cin(in_cin[0][0]),
      .sum(sum1), .cout(cout1), .out_valid(ovld1)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   full_adder_instantiation #(.WIDTH(8), .REG_INPUTS(0)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_vld[1][0]),
      .a(in_a[1][7:0]), .b(in_b[1][7:0]), .cin(in_cin[1][0]),
      .sum(sum8), .cout(cout8), .out_valid(ovld8)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   full_adder_instantiation #(.WIDTH(4), .REG_INPUTS(1)) u_w4r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_vld[2][0]),
      .a(in_a[2][3:0]), .b(in_b[2][3:0]), .cin(in_cin[2][0]),
      .sum(sum4), .cout(cout4), .out_valid(ovld4)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

`ifndef FULL_ADDER_OVF_EN
   assign ovf1 = 1'b0;
   assign ovf8 = 1'b0;
   assign ovf4 = 1'b0;
`endif

   assign got_sum[0]  = int'(sum1);
   assign got_sum[1]  = int'(sum8);
   assign got_sum[2]  = int'(sum4);
   assign got_cout[0] = int'(cout1);
   assign got_cout[1] = int'(cout8);
   assign got_cout[2] = int'(cout4);
   assign got_vld[0]  = int'(ovld1);
   assign got_vld[1]  = int'(ovld8);
   assign got_vld[2]  = int'(ovld4);
   assign got_ovf[0]  = int'(ovf1);
   assign got_ovf[1]  = int'(ovf8);
   assign got_ovf[2]  = int'(ovf4);

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: integer addition, signed overflow judged by the signed result range.
   task automatic ref_add(input int w, input int a, input int b, input int c,
                          output int s, output int co, output int ov);
      int full, sa, sb, r;
      full = a + b + c;
      s    = full % (1 << w);
      co   = full >> w;
      sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      r    = sa + sb + c;
      ov   = (r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1))) ? 1 : 0;
   endtask

   task automatic drive(input int i, input int v, input int a, input int b, input int c);
      in_vld[i] = v;
      in_a[i]   = a;
      in_b[i]   = b;
      in_cin[i] = c;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         ex_sum[i] = 0; ex_cout[i] = 0; ex_ovf[i] = 0; ex_vld[i] = 0;
      end
      p_vld = 0; p_a = 0; p_b = 0; p_cin = 0;
   endtask

   task automatic compare_all(input string when);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s u%0d sum", when, i), got_sum[i], ex_sum[i]);
         check($sformatf("%s u%0d cout", when, i), got_cout[i], ex_cout[i]);
         check($sformatf("%s u%0d vld", when, i), got_vld[i], ex_vld[i]);
`ifdef FULL_ADDER_OVF_EN
         check($sformatf("%s u%0d ovf", when, i), got_ovf[i], ex_ovf[i]);
`endif
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      int s, co, ov;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         ex_vld[i] = in_vld[i];
         if (in_vld[i] != 0) begin
            ref_add(WID[i], in_a[i], in_b[i], in_cin[i], s, co, ov);
            ex_sum[i] = s; ex_cout[i] = co; ex_ovf[i] = ov;
         end
      end
      ex_vld[2] = p_vld;
      if (p_vld != 0) begin
         ref_add(WID[2], p_a, p_b, p_cin, s, co, ov);
         ex_sum[2] = s; ex_cout[2] = co; ex_ovf[2] = ov;
      end
      p_vld = in_vld[2]; p_a = in_a[2]; p_b = in_b[2]; p_cin = in_cin[2];
      #1;
      compare_all("step");
   endtask

   int tbl[8] = '{0, 1, 1, 2, 1, 2, 2, 3};

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      idle_all();
      model_reset();

      #3;
      compare_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // WIDTH=1 truth table.
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, (k >> 2) & 1, (k >> 1) & 1, k & 1);
         step();
         check($sformatf("w1 tbl %0d", k), got_cout[0] * 2 + got_sum[0], tbl[k]);
      end
      idle_all();

      // WIDTH=8 wrap cases.
      drive(1, 1, 8'hFF, 8'h01, 0);
      step();
      check("w8 ff+01 sum", got_sum[1], 8'h00);
      check("w8 ff+01 cout", got_cout[1], 1);
      drive(1, 1, 8'hFF, 8'hFF, 1);
      step();
      check("w8 ff+ff+1 sum", got_sum[1], 8'hFF);
      check("w8 ff+ff+1 cout", got_cout[1], 1);
      drive(1, 1, 0, 0, 0);
      step();
      check("w8 zero sum", got_sum[1], 0);
      check("w8 zero cout", got_cout[1], 0);

      // Hold: 0x5A then idle with random operands.
      drive(1, 1, 8'h50, 8'h0A, 0);
      step();
      check("hold load", got_sum[1], 8'h5A);
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, int'($urandom_range(255)), int'($urandom_range(255)),
               int'($urandom_range(1)));
         step();
         check("hold sum", got_sum[1], 8'h5A);
         check("hold vld", got_vld[1], 0);
      end
      idle_all();

`ifdef FULL_ADDER_OVF_EN
      drive(1, 1, 8'h7F, 8'h01, 0);
      step();
      check("ovf 7f+01 sum", got_sum[1], 8'h80);
      check("ovf 7f+01", got_ovf[1], 1);
      drive(1, 1, 8'h80, 8'hFF, 0);
      step();
      check("ovf 80+ff sum", got_sum[1], 8'h7F);
      check("ovf 80+ff cout", got_cout[1], 1);
      check("ovf 80+ff", got_ovf[1], 1);
      drive(1, 1, 8'h01, 8'h01, 0);
      step();
      check("ovf 01+01", got_ovf[1], 0);
      idle_all();
`endif

      // Registered-input latency: 3+4+1 visible after exactly two edges.
      step();
      drive(2, 1, 3, 4, 1);
      step();
      check("w4r edge1 vld", got_vld[2], 0);
      drive(2, 0, int'($urandom_range(15)), int'($urandom_range(15)), 0);
      step();
      check("w4r edge2 vld", got_vld[2], 1);
      check("w4r sum", got_sum[2], 4'h8);
      check("w4r cout", got_cout[2], 0);

      // Randomized traffic with an asynchronous reset pulse mid-stream.
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 3; i++) begin
            drive(i, int'($urandom_range(3) != 0),
                  int'($urandom_range((1 << WID[i]) - 1)),
                  int'($urandom_range((1 << WID[i]) - 1)),
                  int'($urandom_range(1)));
         end
         if (k == 150) begin
            for (int i = 0; i < 3; i++) in_vld[i] = 1;
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all("async rst");
            #1;
            rst_n = 1'b1;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_full_adder_instantiation
